// File: rtl/snake_pkg.sv
// Shared definitions for the snake game score readout.
// Provides the converter FSM state encoding, active-low seven-segment codes
// ({g,f,e,d,c,b,a}) for digits 0-9 plus a blank code, and digit_to_seg(),
// which maps a BCD nibble to its segment pattern.
package snake_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } conv_state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Non-decimal nibbles blank the digit.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Iterative 8-bit binary to 3-digit BCD converter (double dabble).
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous active-high reset
//   start  in   begin a conversion of bin (honoured only when idle)
//   bin    in   8-bit binary value
//   bcd    out  latched result {hundreds,tens,units}
//   busy   out  high from the start edge until the result is latched (9 cycles)
module bin2bcd8
    import snake_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        busy
);

    conv_state_e state_q, state_d;
    logic [19:0] work_q, work_d;  // {hundreds, tens, units, binary}
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] bcd_q, bcd_d;
    logic        busy_q, busy_d;
    logic [19:0] adj;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        adj     = work_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    work_d  = {12'd0, bin};
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                for (int i = 0; i < 3; i++) begin
                    if (adj[8 + 4*i +: 4] >= 4'd5) begin
                        adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4] + 4'd3;
                    end
                end
                work_d = adj << 1;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bcd_d   = work_q[19:8];
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            work_q  <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;

endmodule

// File: rtl/score_display_driver.sv
// Snake score readout: converts the 8-bit score to BCD and scans it onto a
// 4-digit common-anode seven-segment display (digit 0 = units, 3 = blank).
// Parameters: CLK_HZ, REFRESH_HZ (digit-advance rate, CLK_HZ/REFRESH_HZ >= 2).
// Ports:
//   clk    in   board clock, rising edge
//   reset  in   asynchronous active-high reset
//   score  in   binary score, same clock domain
//   an     out  digit enables, active-low, one-hot
//   seg    out  segments {g,f,e,d,c,b,a}, active-low
//   dp     out  decimal point, active-low, always off
//   bcd    out  latched conversion result {hundreds,tens,units}
//   busy   out  conversion in progress
// Build option: define SCORE_LZ_BLANK_EN to blank leading zeros on the
// hundreds and tens digits.
module score_display_driver
    import snake_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  score,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [11:0] bcd,
    output logic        busy
);

    localparam int unsigned DIV = CLK_HZ / REFRESH_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PrescMax = PW'(DIV - 1);

    logic [7:0]    last_score_q, last_score_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          start;

    // busy is low only while the converter is idle, so a change seen during a
    // conversion waits and is re-compared once the converter returns to idle.
    assign start = !busy && (score != last_score_q);

    bin2bcd8 u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (score),
        .bcd   (bcd),
        .busy  (busy)
    );

    always_comb begin
        last_score_d = start ? score : last_score_q;
        if (presc_q == PrescMax) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + 1'b1;
            idx_d   = idx_q;
        end
    end

    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = SEG_BLANK;
        unique case (idx_q)
            2'd0: seg_d = digit_to_seg(bcd[3:0]);
            2'd1: begin
`ifdef SCORE_LZ_BLANK_EN
                if (bcd[11:4] == 8'd0) seg_d = SEG_BLANK;
                else                   seg_d = digit_to_seg(bcd[7:4]);
`else
                seg_d = digit_to_seg(bcd[7:4]);
`endif
            end
            2'd2: begin
`ifdef SCORE_LZ_BLANK_EN
                if (bcd[11:8] == 4'd0) seg_d = SEG_BLANK;
                else                   seg_d = digit_to_seg(bcd[11:8]);
`else
                seg_d = digit_to_seg(bcd[11:8]);
`endif
            end
            2'd3: seg_d = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_score_q <= '0;
            presc_q      <= '0;
            idx_q        <= '0;
            an_q         <= 4'b1111;
            seg_q        <= SEG_BLANK;
        end else begin
            last_score_q <= last_score_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_score_display_driver.sv
// Bench for score_display_driver at DIV=4 (CLK_HZ=40, REFRESH_HZ=10).
// Stimulus pushes expected BCD results into a queue; a monitor pops one each
// time busy falls and also checks the scan pattern every cycle.
module tb_score_display_driver;

    localparam int DIV = 4;

    logic        clk;
    logic        reset;
    logic [7:0]  score;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [11:0] bcd;
    logic        busy;

    score_display_driver #(
        .CLK_HZ     (40),
        .REFRESH_HZ (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .score (score),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .bcd   (bcd),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] exp_q[$];
    int          done_c[$];
    logic [6:0]  exp_seg[4];
    logic [3:0]  exp_an[4];
    logic        scan_en = 1'b0;
    int          e = 0;      // edges since reset release
    int          cyc = 0;
    int          rise_e = 0;
    logic        busy_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_reset(input string name);
        check({name, ".an"},   32'(an),   32'hf);
        check({name, ".seg"},  32'(seg),  32'h7f);
        check({name, ".dp"},   32'(dp),   32'h1);
        check({name, ".busy"}, 32'(busy), 32'h0);
        check({name, ".bcd"},  32'(bcd),  32'h0);
    endtask

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic set_digits(input logic [11:0] b);
        exp_seg[0] = seg_code(b[3:0]);
        exp_seg[1] = seg_code(b[7:4]);
        exp_seg[2] = seg_code(b[11:8]);
        exp_seg[3] = 7'b1111111;
`ifdef SCORE_LZ_BLANK_EN
        if (b[11:8] == 4'd0) exp_seg[2] = 7'b1111111;
        if (b[11:4] == 8'd0) exp_seg[1] = 7'b1111111;
`endif
    endtask

    // Reference scan position, restarted by reset.
    always @(posedge clk or posedge reset) begin
        if (reset) e <= 0;
        else       e <= e + 1;
    end

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        int idx;
        #1;
        cyc++;
        if (reset) begin
            busy_prev = 1'b0;
            chk_reset("rst");
        end else begin
            if (e == 1) busy_prev = 1'b0;
            idx = ((e - 1) / DIV) % 4;
            check("an", 32'(an), 32'(exp_an[idx]));
            check("dp", 32'(dp), 32'h1);
            if (scan_en) check("seg", 32'(seg), 32'(exp_seg[idx]));
            if (busy && !busy_prev) rise_e = e;
            if (!busy && busy_prev) begin
                check("busy_len", 32'(e - rise_e), 32'd9);
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(bcd), 32'hfff);
                end else begin
                    check("bcd", 32'(bcd), 32'(exp_q.pop_front()));
                    done_c.push_back(cyc);
                end
            end
            busy_prev = busy;
        end
    end

    task automatic drain(input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic scan_window(input logic [11:0] b);
        repeat (3) @(negedge clk);
        set_digits(b);
        scan_en = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic convert(input logic [7:0] s, input logic [11:0] b);
        @(negedge clk);
        scan_en = 1'b0;
        score   = s;
        exp_q.push_back(b);
        drain(40);
        scan_window(b);
    endtask

    initial begin
        exp_an[0] = 4'b1110;
        exp_an[1] = 4'b1101;
        exp_an[2] = 4'b1011;
        exp_an[3] = 4'b0111;
        set_digits(12'h000);
        reset = 1'b1;
        score = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Score equal to last_score after reset: blank scan of zeros, no conversion.
        scan_window(12'h000);

        convert(8'd255, 12'h255);
        convert(8'd7,   12'h007);
        convert(8'd99,  12'h099);
        convert(8'd136, 12'h136);
        convert(8'd128, 12'h128);
        convert(8'd0,   12'h000);

        // Change mid-conversion: second value converted right after the first.
        @(negedge clk);
        scan_en = 1'b0;
        done_c.delete();
        score = 8'd100;
        exp_q.push_back(12'h100);
        exp_q.push_back(12'h042);
        repeat (3) @(negedge clk);
        score = 8'd42;
        drain(60);
        if (done_c.size() >= 2) check("done_gap", 32'(done_c[1] - done_c[0]), 32'd10);
        else                    check("done_count", 32'(done_c.size()), 32'd2);
        scan_window(12'h042);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        scan_en = 1'b0;
        score = 8'd200;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1 chk_reset("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(12'h200);
        @(posedge clk);
        #1 check("busy_restart", 32'(busy), 32'h1);
        drain(40);
        scan_window(12'h200);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
